// File: rtl/conv_stream_sequencer_pkg.sv
// Shared definitions for the streaming convolution sequencer: FSM states,
// derived width helpers and flat-vector index helpers for pixels/coefficients.
package conv_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Accumulator width large enough that K*K full-scale products never overflow.
  function automatic int acc_w(input int dw, input int k);
    return 2 * dw + $clog2(k * k);
  endfunction

  // Index register width for a counter spanning 0..n-1.
  function automatic int idx_w(input int n);
    return $clog2(n) + 1;
  endfunction

  // Element number of (row, col) in a row-major packed array with 'cols' columns.
  function automatic int flat_index(input int row, input int col, input int cols);
    return row * cols + col;
  endfunction

endpackage

// File: rtl/conv_stream_sequencer_if.sv
// Result stream of the convolution sequencer: valid/ready handshake plus the
// result value, its raster position and an end-of-frame marker.
interface conv_stream_sequencer_if #(
  parameter int OUT_W = 8,
  parameter int RW    = 2,
  parameter int CW    = 2
);
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [RW-1:0]    out_row;
  logic [CW-1:0]    out_col;
  logic             out_last;

  modport master (output out_valid, out_data, out_row, out_col, out_last, input out_ready);
  modport slave  (input out_valid, out_data, out_row, out_col, out_last, output out_ready);
endinterface

// File: rtl/conv_stream_sequencer_mac.sv
// Single multiply-accumulate lane. sum_o is the value the accumulator takes on
// the next enabled edge, so the caller can register a finished result in the
// same cycle as the final product.
module conv_mac_unit #(
  parameter int DW    = 8,
  parameter int ACC_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clear_first_i,
  input  logic [DW-1:0]    a_i,
  input  logic [DW-1:0]    b_i,
  output logic [ACC_W-1:0] sum_o
);
  logic [2*DW-1:0]  prod_s;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;

  // Next accumulator value: restart from the product on the first tap of a window.
  always_comb begin
    prod_s = a_i * b_i;
    if (clear_first_i) begin
      acc_d = ACC_W'(prod_s);
    end else begin
      acc_d = acc_q + ACC_W'(prod_s);
    end
  end

  assign sum_o = acc_d;

  // Accumulator register, advanced only while a window is being summed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_d;
    end
  end
endmodule

// File: rtl/conv_stream_sequencer.sv
// Snapshots an image and a KxK filter, then walks every valid output position
// in raster order, summing one product per cycle and presenting each result on
// a valid/ready stream. Supports convolution (flipped filter) or correlation,
// and either saturating or wrapping output narrowing.
module conv_stream_sequencer
  import conv_seq_pkg::*;
#(
  parameter int DW    = 8,
  parameter int IMG_H = 4,
  parameter int IMG_W = 4,
  parameter int K     = 3,
  parameter int OUT_W = 8,
  parameter int SAT   = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      mode,
  input  logic [IMG_H*IMG_W*DW-1:0] data_in,
  input  logic [K*K*DW-1:0]         filter_in,
  output logic                      busy,
  output logic                      done,
  conv_stream_sequencer_if.master   out_if
);
  localparam int OH    = IMG_H - K + 1;
  localparam int OW    = IMG_W - K + 1;
  localparam int ACC_W = acc_w(DW, K);
  localparam int RW    = idx_w(OH);
  localparam int CW    = idx_w(OW);
  localparam int KW    = idx_w(K);

  state_e                    state_q, state_d;
  logic [IMG_H*IMG_W*DW-1:0] img_q, img_d;
  logic [K*K*DW-1:0]         filt_q, filt_d;
  logic                      mode_q, mode_d;
  logic [RW-1:0]             oy_q, oy_d;
  logic [CW-1:0]             ox_q, ox_d;
  logic [KW-1:0]             kr_q, kr_d;
  logic [KW-1:0]             kc_q, kc_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      valid_q, valid_d;
  logic [OUT_W-1:0]          data_q, data_d;
  logic                      last_q, last_d;

  int                        pix_idx_s;
  int                        coef_idx_s;
  logic [DW-1:0]             pix_s;
  logic [DW-1:0]             coef_s;
  logic                      mac_en_s;
  logic                      mac_clr_s;
  logic [ACC_W-1:0]          mac_sum_s;
  logic [ACC_W+OUT_W-1:0]    sum_ext_s;
  logic [OUT_W-1:0]          narrow_s;

  // Operand fetch: pixel under the current tap and the matching (possibly flipped) coefficient.
  always_comb begin
    pix_idx_s = flat_index(int'(oy_q) + int'(kr_q), int'(ox_q) + int'(kc_q), IMG_W);
    if (mode_q) begin
      coef_idx_s = flat_index(int'(kr_q), int'(kc_q), K);
    end else begin
      coef_idx_s = flat_index(K - 1 - int'(kr_q), K - 1 - int'(kc_q), K);
    end
    pix_s  = img_q[pix_idx_s*DW +: DW];
    coef_s = filt_q[coef_idx_s*DW +: DW];
  end

  conv_mac_unit #(.DW(DW), .ACC_W(ACC_W)) u_mac (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_i         (mac_en_s),
    .clear_first_i(mac_clr_s),
    .a_i          (pix_s),
    .b_i          (coef_s),
    .sum_o        (mac_sum_s)
  );

  // Narrow the finished sum: clamp to all-ones when saturating, else keep low bits.
  always_comb begin
    sum_ext_s = {{OUT_W{1'b0}}, mac_sum_s};
    if ((SAT != 0) && ((sum_ext_s >> OUT_W) != '0)) begin
      narrow_s = {OUT_W{1'b1}};
    end else begin
      narrow_s = sum_ext_s[OUT_W-1:0];
    end
  end

  // Next-state and datapath control for IDLE -> MAC -> OUT -> (MAC | DONE) -> IDLE.
  always_comb begin
    state_d   = state_q;
    img_d     = img_q;
    filt_d    = filt_q;
    mode_d    = mode_q;
    oy_d      = oy_q;
    ox_d      = ox_q;
    kr_d      = kr_q;
    kc_d      = kc_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    valid_d   = valid_q;
    data_d    = data_q;
    last_d    = last_q;
    mac_en_s  = 1'b0;
    mac_clr_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          img_d   = data_in;
          filt_d  = filter_in;
          mode_d  = mode;
          oy_d    = '0;
          ox_d    = '0;
          kr_d    = '0;
          kc_d    = '0;
          busy_d  = 1'b1;
          state_d = ST_MAC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MAC: begin
        mac_en_s  = 1'b1;
        mac_clr_s = (kr_q == KW'(0)) && (kc_q == KW'(0));
        if (kc_q == KW'(K - 1)) begin
          kc_d = '0;
          if (kr_q == KW'(K - 1)) begin
            kr_d    = '0;
            valid_d = 1'b1;
            data_d  = narrow_s;
            last_d  = (oy_q == RW'(OH - 1)) && (ox_q == CW'(OW - 1));
            state_d = ST_OUT;
          end else begin
            kr_d = kr_q + KW'(1);
          end
        end else begin
          kc_d = kc_q + KW'(1);
        end
      end
      ST_OUT: begin
        if (out_if.out_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (last_q) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            if (ox_q == CW'(OW - 1)) begin
              ox_d = '0;
              oy_d = oy_q + RW'(1);
            end else begin
              ox_d = ox_q + CW'(1);
            end
            state_d = ST_MAC;
          end
        end else begin
          state_d = ST_OUT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, snapshot, index and output registers; reset discards any run in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      img_q   <= '0;
      filt_q  <= '0;
      mode_q  <= 1'b0;
      oy_q    <= '0;
      ox_q    <= '0;
      kr_q    <= '0;
      kc_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      img_q   <= img_d;
      filt_q  <= filt_d;
      mode_q  <= mode_d;
      oy_q    <= oy_d;
      ox_q    <= ox_d;
      kr_q    <= kr_d;
      kc_q    <= kc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign out_if.out_valid = valid_q;
  assign out_if.out_data  = data_q;
  assign out_if.out_row   = oy_q;
  assign out_if.out_col   = ox_q;
  assign out_if.out_last  = last_q;
endmodule
